control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter REGS, default 16, meaning general-register count and the width of rin/rout (2..16).
REQ-002 SHALL have port clock  in  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port clear  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ir  in  32  instruction register contents: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-005 SHALL have port mem_ready  in  1  memory read-data-valid handshake.
REQ-006 SHALL have port start  in  1  resume pulse from HALT.
REQ-007 SHALL have outputs pco, pci, iri, mari, mdri, mdro, read, incpc, yi, zi, zlowo, zhigho, hii, loi  out  1 each  bus-drive and load strobes to the datapath.
REQ-008 SHALL have outputs rin, rout  out  REGS  one-hot register load / bus-drive selects.
REQ-009 SHALL have outputs alu_op  out  4 (ADD=0, SUB=1, AND=2, OR=3, MUL=4, PASS=F); run  out  1; state  out  4 (debug).

Function
REQ-010 SHALL be a Moore machine: every output decodes from the state register and ir only; no combinational path from mem_ready or start to any output.
REQ-011 SHALL assert at most one bus driver (pco, mdro, zlowo, zhigho, any rout bit) in any cycle.
REQ-012 SHALL use states T0=0, T1=1, T2=2, T3=3, T4=4, T5=5, T6=6, HALT=8, FAULT=9, reported on state.
REQ-013 T0 SHALL assert pco, mari, incpc, zi, alu_op=PASS; next T1.
REQ-014 T1 SHALL assert zlowo, pci, read, mdri; it SHALL hold T1 while mem_ready=0 and re-assert pci/mdri every waiting cycle; next T2 when mem_ready=1.
REQ-015 T2 SHALL assert mdro, iri; next T3.
REQ-016 T3 SHALL decode op: ADD 00011, SUB 00100, AND 00101, OR 00110 assert rout[rb], yi, next T4; NOP 11010 next T0; HALT 11011 next HALT; any other op next FAULT.
REQ-017 T4 SHALL assert rout[rc], zi, alu_op per op; next T5.
REQ-018 T5 SHALL assert zlowo, rin[ra] for ALU ops, next T0.
REQ-019 A select field >= REGS SHALL route T3 to FAULT instead of T4.
REQ-020 HALT SHALL drive run=0, all strobes 0; start=1 moves to T0; start=0 holds.
REQ-021 FAULT SHALL drive run=0, all strobes 0, ignore start, and exit only via clear.
REQ-022 run SHALL be 1 in T0..T6 and 0 in HALT/FAULT.
REQ-023 A one-hot select SHALL be REGS bits wide with exactly the indexed bit set, all others 0.

Reset
REQ-024 clear=0 SHALL asynchronously force state=T0 and all outputs 0 (run included) for as long as clear is low, overriding any state mid-instruction or mid-wait.
REQ-025 On the first rising clock edge with clear=1, outputs SHALL follow T0 decode with run=1; the machine SHALL advance to T1 on the following edge.

Configuration
REQ-026 Macro CTRL_MUL_EN SHALL compile in multiply support.
REQ-027 With CTRL_MUL_EN defined, op 01111 (MUL) SHALL run T3 rout[ra],yi; T4 rout[rb],zi,alu_op=MUL; T5 zlowo,loi; T6 zhigho,hii; then T0.
REQ-028 Without CTRL_MUL_EN, op 01111 SHALL go to FAULT, state T6 SHALL be unreachable, and hii/loi/zhigho SHALL be tied 0.

Verification
REQ-029 Release clear, mem_ready=1, ir=ADD ra=3 rb=1 rc=2 -> states 0,1,2,3,4,5,0; T3 rout=0x0002 yi; T4 rout=0x0004 alu_op=0 zi; T5 rin=0x0008 zlowo; 6 cycles per instruction.
REQ-030 Hold mem_ready=0 for 3 cycles in T1 -> state stays 1 for 4 cycles with read=1, zero bus-driver conflicts, then T2.
REQ-031 ir=HALT -> state 8, run=0 after T3; start held 0 for 10 cycles -> state 8; 1-cycle start pulse -> T0 next edge.
REQ-032 ir op=11111, then ir=ADD with ra=0xF under REGS=8 -> each reaches FAULT (9); start ignored; clear low then high -> T0.
REQ-033 Assert clear in T4 between edges -> all outputs 0 immediately, state=0 without clock edge.
REQ-034 ir=MUL ra=1 rb=2: with CTRL_MUL_EN -> T5 loi, T6 hii zhigho, 7 cycles; without -> FAULT after T3.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_sequencer                                          |
// | Description : Hard-wired Moore control unit for a single-bus datapath.   |
// |               It runs fetch T0..T2, decodes the opcode in T3 and runs    |
// |               ALU instructions in T4..T5 (T6 for multiply). It also      |
// |               provides a HALT state resumed by start, and a FAULT state  |
// |               that only clear can leave.                                 |
// |               Optional multiply support: define CTRL_MUL_EN.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module control_sequencer #(
    parameter int REGS = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    input  logic            start,
    output logic            pco,
    output logic            pci,
    output logic            iri,
    output logic            mari,
    output logic            mdri,
    output logic            mdro,
    output logic            read,
    output logic            incpc,
    output logic            yi,
    output logic            zi,
    output logic            zlowo,
    output logic            zhigho,
    output logic            hii,
    output logic            loi,
    output logic [REGS-1:0] rin,
    output logic [REGS-1:0] rout,
    output logic [3:0]      alu_op,
    output logic            run,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        ST_T0    = 4'd0,
        ST_T1    = 4'd1,
        ST_T2    = 4'd2,
        ST_T3    = 4'd3,
        ST_T4    = 4'd4,
        ST_T5    = 4'd5,
        ST_T6    = 4'd6,
        ST_HALT  = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    localparam logic [4:0] c_OP_ADD   = 5'b00011;
    localparam logic [4:0] c_OP_SUB   = 5'b00100;
    localparam logic [4:0] c_OP_AND   = 5'b00101;
    localparam logic [4:0] c_OP_OR    = 5'b00110;
    localparam logic [4:0] c_OP_NOP   = 5'b11010;
    localparam logic [4:0] c_OP_HALT  = 5'b11011;
`ifdef CTRL_MUL_EN
    localparam logic [4:0] c_OP_MUL   = 5'b01111;
    localparam logic [3:0] c_ALU_MUL  = 4'h4;
`endif
    localparam logic [3:0] c_ALU_ADD  = 4'h0;
    localparam logic [3:0] c_ALU_SUB  = 4'h1;
    localparam logic [3:0] c_ALU_AND  = 4'h2;
    localparam logic [3:0] c_ALU_OR   = 4'h3;
    localparam logic [3:0] c_ALU_PASS = 4'hF;
    localparam logic [4:0] c_REGS     = 5'(REGS);

    state_t     r_state;
    logic       r_active;   // low until the first edge after clear releases

    logic [4:0] w_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_is_alu;
    logic       w_is_mul;
    logic [3:0] w_alu_code;
    logic       w_alu_ok;
    logic       w_mul_ok;
    logic       w_unused;

    assign w_op     = ir[31:27];
    assign w_ra     = ir[26:23];
    assign w_rb     = ir[22:19];
    assign w_rc     = ir[18:15];
    assign w_unused = ^ir[14:0];

    assign w_alu_ok = ({1'b0, w_ra} < c_REGS) && ({1'b0, w_rb} < c_REGS) &&
                      ({1'b0, w_rc} < c_REGS);
    assign w_mul_ok = ({1'b0, w_ra} < c_REGS) && ({1'b0, w_rb} < c_REGS);

`ifdef CTRL_MUL_EN
    assign w_is_mul = (w_op == c_OP_MUL);
`else
    assign w_is_mul = 1'b0;
`endif

    // One-hot register select; an out-of-range index yields all zeros
    function automatic logic [REGS-1:0] onehot(input logic [3:0] idx);
        logic [REGS-1:0] v;
        v = '0;
        for (int i = 0; i < REGS; i++) begin
            if (idx == 4'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Classify the opcode as a two-operand ALU instruction and pick its ALU code
    always_comb begin
        w_is_alu   = 1'b1;
        w_alu_code = c_ALU_ADD;
        case (w_op)
            c_OP_ADD: w_alu_code = c_ALU_ADD;
            c_OP_SUB: w_alu_code = c_ALU_SUB;
            c_OP_AND: w_alu_code = c_ALU_AND;
            c_OP_OR:  w_alu_code = c_ALU_OR;
            default:  w_is_alu   = 1'b0;
        endcase
    end

    // State register; the first edge after clear only arms the machine so T0 is seen for a full cycle
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= ST_T0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            r_active <= 1'b1;
        end else begin
            case (r_state)
                ST_T0: r_state <= ST_T1;
                ST_T1: if (mem_ready) r_state <= ST_T2;
                ST_T2: r_state <= ST_T3;
                ST_T3: begin
                    if (w_is_alu)              r_state <= w_alu_ok ? ST_T4 : ST_FAULT;
                    else if (w_is_mul)         r_state <= w_mul_ok ? ST_T4 : ST_FAULT;
                    else if (w_op == c_OP_NOP)  r_state <= ST_T0;
                    else if (w_op == c_OP_HALT) r_state <= ST_HALT;
                    else                       r_state <= ST_FAULT;
                end
                ST_T4:    r_state <= ST_T5;
                ST_T5:    r_state <= w_is_mul ? ST_T6 : ST_T0;
                ST_T6:    r_state <= ST_T0;
                ST_HALT:  if (start) r_state <= ST_T0;
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_FAULT;
            endcase
        end
    end

    // Moore output decode from the state register and ir; everything is quiet until armed
    always_comb begin
        pco    = 1'b0;
        pci    = 1'b0;
        iri    = 1'b0;
        mari   = 1'b0;
        mdri   = 1'b0;
        mdro   = 1'b0;
        read   = 1'b0;
        incpc  = 1'b0;
        yi     = 1'b0;
        zi     = 1'b0;
        zlowo  = 1'b0;
        zhigho = 1'b0;
        hii    = 1'b0;
        loi    = 1'b0;
        rin    = '0;
        rout   = '0;
        alu_op = 4'h0;
        run    = 1'b0;
        if (r_active) begin
            run = (r_state != ST_HALT) && (r_state != ST_FAULT);
            case (r_state)
                ST_T0: begin
                    pco    = 1'b1;
                    mari   = 1'b1;
                    incpc  = 1'b1;
                    zi     = 1'b1;
                    alu_op = c_ALU_PASS;
                end
                ST_T1: begin
                    zlowo = 1'b1;
                    pci   = 1'b1;
                    read  = 1'b1;
                    mdri  = 1'b1;
                end
                ST_T2: begin
                    mdro = 1'b1;
                    iri  = 1'b1;
                end
                ST_T3: begin
                    if (w_is_alu) begin
                        rout = onehot(w_rb);
                        yi   = 1'b1;
                    end else if (w_is_mul) begin
                        rout = onehot(w_ra);
                        yi   = 1'b1;
                    end
                end
                ST_T4: begin
                    if (w_is_alu) begin
                        rout   = onehot(w_rc);
                        zi     = 1'b1;
                        alu_op = w_alu_code;
                    end
`ifdef CTRL_MUL_EN
                    else if (w_is_mul) begin
                        rout   = onehot(w_rb);
                        zi     = 1'b1;
                        alu_op = c_ALU_MUL;
                    end
`endif
                end
                ST_T5: begin
                    zlowo = 1'b1;
                    if (w_is_alu) rin = onehot(w_ra);
`ifdef CTRL_MUL_EN
                    if (w_is_mul) loi = 1'b1;
`endif
                end
                ST_T6: begin
`ifdef CTRL_MUL_EN
                    zhigho = 1'b1;
                    hii    = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                       |
// | Description : Randomized self-checking bench for control_sequencer.      |
// |               Each instruction is expanded into its expected list of     |
// |               micro-steps and then compared cycle by cycle.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

    localparam int REGS = 8;
`ifdef CTRL_MUL_EN
    localparam bit c_MUL_ON = 1'b1;
`else
    localparam bit c_MUL_ON = 1'b0;
`endif

    // Strobe bit weights in the observation vector
    localparam logic [13:0] S_PCO    = 14'h2000;
    localparam logic [13:0] S_PCI    = 14'h1000;
    localparam logic [13:0] S_IRI    = 14'h0800;
    localparam logic [13:0] S_MARI   = 14'h0400;
    localparam logic [13:0] S_MDRI   = 14'h0200;
    localparam logic [13:0] S_MDRO   = 14'h0100;
    localparam logic [13:0] S_READ   = 14'h0080;
    localparam logic [13:0] S_INCPC  = 14'h0040;
    localparam logic [13:0] S_YI     = 14'h0020;
    localparam logic [13:0] S_ZI     = 14'h0010;
    localparam logic [13:0] S_ZLOWO  = 14'h0008;
    localparam logic [13:0] S_ZHIGHO = 14'h0004;
    localparam logic [13:0] S_HII    = 14'h0002;
    localparam logic [13:0] S_LOI    = 14'h0001;

    logic            clock = 1'b0;
    logic            clear = 1'b0;
    logic [31:0]     ir = 32'h0;
    logic            mem_ready = 1'b0;
    logic            start = 1'b0;
    logic            pco, pci, iri, mari, mdri, mdro, read, incpc;
    logic            yi, zi, zlowo, zhigho, hii, loi, run;
    logic [REGS-1:0] rin, rout;
    logic [3:0]      alu_op, state;

    control_sequencer #(.REGS(REGS)) u_dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .start(start),
        .pco(pco), .pci(pci), .iri(iri), .mari(mari), .mdri(mdri), .mdro(mdro),
        .read(read), .incpc(incpc), .yi(yi), .zi(zi), .zlowo(zlowo), .zhigho(zhigho),
        .hii(hii), .loi(loi), .rin(rin), .rout(rout), .alu_op(alu_op), .run(run),
        .state(state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] observed();
        return 64'({state, run, pco, pci, iri, mari, mdri, mdro, read, incpc,
                    yi, zi, zlowo, zhigho, hii, loi, rin, rout, alu_op});
    endfunction

    function automatic int bus_drivers();
        return int'(pco) + int'(mdro) + int'(zlowo) + int'(zhigho) + $countones(rout);
    endfunction

    function automatic logic [REGS-1:0] oh(input int idx);
        if (idx < REGS) return REGS'(1) << idx;
        return '0;
    endfunction

    // Expected micro-step list for the current instruction
    logic [63:0] exp_q[$];
    int          st_q[$];
    bit          mr_q[$];

    task automatic push(input int st, input logic [13:0] s, input logic [REGS-1:0] ri,
                        input logic [REGS-1:0] ro, input logic [3:0] a, input bit mr);
        exp_q.push_back(64'({4'(st), (st <= 6) ? 1'b1 : 1'b0, s, ri, ro, a}));
        st_q.push_back(st);
        mr_q.push_back(mr);
    endtask

    // Expand one instruction from its opcode semantics, starting at fetch
    task automatic build_instr(input logic [31:0] iv, input int waits);
        int op, ra, rb, rc, code;
        bit is_alu;
        op = int'(iv[31:27]); ra = int'(iv[26:23]); rb = int'(iv[22:19]); rc = int'(iv[18:15]);
        exp_q.delete(); st_q.delete(); mr_q.delete();
        push(0, S_PCO | S_MARI | S_INCPC | S_ZI, '0, '0, 4'hF, 1'($urandom));
        for (int k = 0; k <= waits; k++)
            push(1, S_ZLOWO | S_PCI | S_READ | S_MDRI, '0, '0, 4'h0, k == waits);
        push(2, S_MDRO | S_IRI, '0, '0, 4'h0, 1'($urandom));
        is_alu = (op >= 3 && op <= 6);
        code   = op - 3;
        if (is_alu) begin
            push(3, S_YI, '0, oh(rb), 4'h0, 1'($urandom));
            if (ra < REGS && rb < REGS && rc < REGS) begin
                push(4, S_ZI, '0, oh(rc), 4'(code), 1'($urandom));
                push(5, S_ZLOWO, oh(ra), '0, 4'h0, 1'($urandom));
            end else push(9, '0, '0, '0, 4'h0, 1'($urandom));
        end else if (op == 15 && c_MUL_ON) begin
            push(3, S_YI, '0, oh(ra), 4'h0, 1'($urandom));
            if (ra < REGS && rb < REGS) begin
                push(4, S_ZI, '0, oh(rb), 4'h4, 1'($urandom));
                push(5, S_ZLOWO | S_LOI, '0, '0, 4'h0, 1'($urandom));
                push(6, S_ZHIGHO | S_HII, '0, '0, 4'h0, 1'($urandom));
            end else push(9, '0, '0, '0, 4'h0, 1'($urandom));
        end else begin
            push(3, '0, '0, '0, 4'h0, 1'($urandom));
            if (op == 27)      push(8, '0, '0, '0, 4'h0, 1'($urandom));
            else if (op != 26) push(9, '0, '0, '0, 4'h0, 1'($urandom));
        end
    endtask

    // Drive clear low between edges, confirm outputs drop without a clock edge, then re-arm
    task automatic do_reset();
        #2 clear = 1'b0;
        #1 check_eq("clear_async", observed(), 64'h0);
        @(posedge clock); #1;
        check_eq("clear_hold", observed(), 64'h0);
        @(negedge clock) clear = 1'b1;
        #1 check_eq("clear_release", observed(), 64'h0);
        @(posedge clock); #1;
    endtask

    // Run one instruction from T0; optionally pull clear while in state abort_st
    task automatic do_instr(input logic [31:0] iv, input int waits, input int abort_st);
        int last;
        build_instr(iv, waits);
        ir = iv;
        last = st_q[st_q.size() - 1];
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = mr_q[i];
            start     = (st_q[i] == 8) ? 1'b0 : 1'($urandom);
            check_eq($sformatf("step_st%0d", st_q[i]), observed(), exp_q[i]);
            check_eq("bus_drivers_le1", 64'(bus_drivers() <= 1), 64'd1);
            if (st_q[i] == abort_st) begin
                start = 1'b0;
                do_reset();
                return;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        mem_ready = 1'b0;
        if (last == 8) begin
            for (int k = 0; k < 10; k++) begin
                check_eq("halt_hold", 64'({state, run}), 64'({4'd8, 1'b0}));
                @(posedge clock); #1;
            end
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            check_eq("halt_resume", 64'({state, run}), 64'({4'd0, 1'b1}));
        end else if (last == 9) begin
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            check_eq("fault_ignores_start", observed(), 64'({4'd9, 1'b0}) << (14 + 2*REGS + 4));
            do_reset();
        end
    endtask

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    endfunction

    initial begin
        int ops[8];
        int op, ra, rb, rc;
        ops = '{3, 4, 5, 6, 15, 26, 27, 31};
        #1 check_eq("reset_state", observed(), 64'h0);
        repeat (2) @(posedge clock);
        #1 check_eq("reset_hold", observed(), 64'h0);
        @(negedge clock) clear = 1'b1;
        @(posedge clock); #1;

        do_instr(mk_ir(3, 3, 1, 2), 0, -1);    // ADD r3 = r1 + r2
        do_instr(mk_ir(4, 2, 5, 6), 3, -1);    // SUB with three memory wait cycles
        do_instr(mk_ir(27, 0, 0, 0), 1, -1);   // HALT then resume
        do_instr(mk_ir(31, 0, 0, 0), 0, -1);   // illegal opcode
        do_instr(mk_ir(3, 15, 1, 2), 0, -1);   // destination out of range
        do_instr(mk_ir(15, 1, 2, 0), 0, -1);   // MUL
        do_instr(mk_ir(5, 1, 2, 3), 2, 4);     // clear pulled mid-instruction in T4
        do_instr(mk_ir(26, 0, 0, 0), 0, -1);   // NOP

        for (int n = 0; n < 120; n++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, REGS-1)) : int'($urandom_range(0, 15));
            rb = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, REGS-1)) : int'($urandom_range(0, 15));
            rc = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, REGS-1)) : int'($urandom_range(0, 15));
            do_instr(mk_ir(op, ra, rb, rc), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
